// File: rtl/arcade_input_conditioner_pkg.sv
// Shared definitions for the arcade input conditioner: raw_in bit map, coin FSM states, counter sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package arcade_input_pkg;

    // Bit positions inside raw_in / btn_out
    localparam int IDX_R      = 0;
    localparam int IDX_L      = 1;
    localparam int IDX_D      = 2;
    localparam int IDX_U      = 3;
    localparam int IDX_FIRE   = 4;
    localparam int IDX_BOMB   = 5;
    localparam int IDX_START1 = 6;
    localparam int IDX_START2 = 7;
    localparam int IDX_COIN1  = 8;
    localparam int IDX_COIN2  = 9;

    localparam int NUM_RAW = 10;
    localparam int NUM_BTN = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE   = 2'd1,
        HOLDOFF = 2'd2
    } coin_state_t;

    // Counter width able to hold 0..n; never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/arcade_input_conditioner_if.sv
// Control bundle between the player-input merge and the game core.
// Latency: n/a (wiring only).
// Backpressure: none; every signal is a level or a one-cycle strobe.
interface arcade_input_conditioner_if;
    logic [9:0] raw_in;
    logic       rot_en;
    logic [7:0] btn_out;
    logic       coin_out;
    logic [1:0] coin_pending;
    logic       coin_drop;

    // Input-merge side: supplies raw controls, observes conditioned outputs
    modport master (
        output raw_in, rot_en,
        input  btn_out, coin_out, coin_pending, coin_drop
    );

    // Conditioner side
    modport slave (
        input  raw_in, rot_en,
        output btn_out, coin_out, coin_pending, coin_drop
    );
endinterface

// File: rtl/arcade_input_conditioner_debounce_bit.sv
// Single-bit debouncer: output follows input only after DEBOUNCE_CYC consecutive differing samples.
// Latency: DEBOUNCE_CYC edges after the input settles (1 edge when DEBOUNCE_CYC = 0).
// Backpressure: none; free-running per clock.
module debounce_bit
    import arcade_input_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 18000
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic din,
    output logic dout
);

    generate
        if (DEBOUNCE_CYC == 0) begin : g_pass
            // No filtering requested: plain register stage
            always_ff @(posedge clk_sys or posedge reset) begin
                if (reset) dout <= 1'b0;
                else       dout <= din;
            end
        end else begin : g_cnt
            localparam int W = cnt_width(DEBOUNCE_CYC);
            localparam logic [W-1:0] LAST = W'(DEBOUNCE_CYC - 1);

            logic [W-1:0] cnt;

            // Count consecutive samples that disagree with the output; any agreeing sample restarts the count
            always_ff @(posedge clk_sys or posedge reset) begin
                if (reset) begin
                    dout <= 1'b0;
                    cnt  <= '0;
                end else if (din == dout) begin
                    cnt <= '0;
                end else if (cnt == LAST) begin
                    dout <= din;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + W'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/arcade_input_conditioner.sv
// Debounces all controls, rotates directions for vertical cabinets, and shapes coins into queued fixed-width pulses.
// Latency: buttons DEBOUNCE_CYC+1 edges; coin pulse rises 2 edges after the debounced coin edge when idle.
// Backpressure: none upstream; coins beyond COIN_QMAX pending are discarded and flagged on coin_drop.
module arcade_input_conditioner
    import arcade_input_pkg::*;
#(
    parameter int DEBOUNCE_CYC     = 18000,
    parameter int COIN_PULSE_CYC   = 1800000,
    parameter int COIN_HOLDOFF_CYC = 1800000,
    parameter int COIN_QMAX        = 3
) (
    input  logic                        clk_sys,
    input  logic                        reset,
    arcade_input_conditioner_if.slave   io
);

    // A zero-length phase still lasts one cycle
    localparam int PULSE_EFF = (COIN_PULSE_CYC   < 1) ? 1 : COIN_PULSE_CYC;
    localparam int HOLD_EFF  = (COIN_HOLDOFF_CYC < 1) ? 1 : COIN_HOLDOFF_CYC;
    localparam int CNT_MAX   = (PULSE_EFF > HOLD_EFF) ? PULSE_EFF : HOLD_EFF;
    localparam int CNT_W     = cnt_width(CNT_MAX);

    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_EFF - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_EFF - 1);
    localparam logic [2:0]       QMAX       = 3'(COIN_QMAX);

    logic [NUM_RAW-1:0] deb;
    logic [NUM_BTN-1:0] btn_nxt;
    logic [NUM_BTN-1:0] btn_q;
    logic [1:0]         coin_prev;
    logic [1:0]         coin_rise;
    logic [1:0]         coin_inc;
    logic               coin_deq;
    logic [2:0]         coin_sum;
    logic [1:0]         pending_q;
    logic               drop_q;
    logic               coin_out_q;
    coin_state_t        state;
    logic [CNT_W-1:0]   cnt;

    genvar g;
    generate
        for (g = 0; g < NUM_RAW; g++) begin : g_deb
            debounce_bit #(
                .DEBOUNCE_CYC (DEBOUNCE_CYC)
            ) u_deb (
                .clk_sys (clk_sys),
                .reset   (reset),
                .din     (io.raw_in[g]),
                .dout    (deb[g])
            );
        end
    endgenerate

    // Direction remap for a rotated monitor; buttons and starts pass straight through
    always_comb begin
        btn_nxt = deb[NUM_BTN-1:0];
        if (io.rot_en) begin
            btn_nxt[IDX_U] = deb[IDX_R];
            btn_nxt[IDX_R] = deb[IDX_D];
            btn_nxt[IDX_D] = deb[IDX_L];
            btn_nxt[IDX_L] = deb[IDX_U];
        end
    end

    // Register the remapped buttons toward the core
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) btn_q <= '0;
        else       btn_q <= btn_nxt;
    end

    // Coin enqueue/dequeue arithmetic: both slots can rise together, FSM takes at most one
    always_comb begin
        coin_rise = {deb[IDX_COIN2], deb[IDX_COIN1]} & ~coin_prev;
        coin_inc  = {1'b0, coin_rise[0]} + {1'b0, coin_rise[1]};
        coin_deq  = (state == IDLE) && (pending_q != 2'd0);
        coin_sum  = {1'b0, pending_q} + {1'b0, coin_inc} - {2'b00, coin_deq};
    end

    // Pending-coin counter with saturation and a single drop strobe per overflowing cycle
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            coin_prev <= 2'b00;
            pending_q <= 2'd0;
            drop_q    <= 1'b0;
        end else begin
            coin_prev <= {deb[IDX_COIN2], deb[IDX_COIN1]};
            if (coin_sum > QMAX) begin
                pending_q <= QMAX[1:0];
                drop_q    <= 1'b1;
            end else begin
                pending_q <= coin_sum[1:0];
                drop_q    <= 1'b0;
            end
        end
    end

    // Coin pulse shaper: IDLE -> PULSE (coin high) -> HOLDOFF (coin low) -> IDLE
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            coin_out_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (coin_deq) begin
                        state      <= PULSE;
                        coin_out_q <= 1'b1;
                        cnt        <= '0;
                    end
                end
                PULSE: begin
                    if (cnt == PULSE_LAST) begin
                        state      <= HOLDOFF;
                        coin_out_q <= 1'b0;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HOLDOFF: begin
                    if (cnt == HOLD_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    cnt        <= '0;
                    coin_out_q <= 1'b0;
                end
            endcase
        end
    end

    assign io.btn_out      = btn_q;
    assign io.coin_out     = coin_out_q;
    assign io.coin_pending = pending_q;
    assign io.coin_drop    = drop_q;

endmodule

// File: doc/arcade_input_conditioner.md
Name: arcade_input_conditioner

Overview:
- Sits between the player-input merge (USB joystick OR DB9 pad OR PS/2 keys) and the game core's control inputs.
- Debounces every button and remaps directions for rotated cabinets.
- Turns any coin press into a core-safe coin pulse of fixed width, then enforces a hold-off.
- Queues up to 3 coins that arrive during a pulse or hold-off, so short or bouncy coin presses are neither lost nor doubled.

Parameters:
DEBOUNCE_CYC, 18000, consecutive stable cycles required before a debounced bit changes (1 ms at 18 MHz); 0 = registered pass-through
COIN_PULSE_CYC, 1800000, cycles coin_out stays high per coin (100 ms)
COIN_HOLDOFF_CYC, 1800000, cycles coin_out stays low after each pulse before the next queued coin
COIN_QMAX, 3, saturation value of the pending-coin counter

Ports:
clk_sys  in  1  system clock
reset  in  1  asynchronous active-high reset
raw_in  in  10  merged raw controls, synchronous to clk_sys: [0]R [1]L [2]D [3]U [4]fire [5]bomb [6]start1 [7]start2 [8]coin1 [9]coin2
rot_en  in  1  1 = rotate directions 90 degrees for a vertical screen shown horizontal
btn_out  out  8  debounced and remapped [7:0], same bit order as raw_in[7:0]
coin_out  out  1  shaped coin pulse to the core
coin_pending  out  2  current queue depth
coin_drop  out  1  one-cycle strobe: a coin was discarded because the queue was full

Behaviour:
- Reset (async assert, sync deassert is the caller's job): btn_out=0, coin_out=0, coin_pending=0, coin_drop=0, all counters 0, FSM=IDLE. Reset mid-pulse drops coin_out in the same instant and loses any queued coins.
- Debounce, per bit, 10 independent instances:
  - State: out bit plus counter of width clog2(DEBOUNCE_CYC+1).
  - If in==out, the counter clears.
  - Otherwise the counter increments. On the edge where in!=out and counter==DEBOUNCE_CYC-1, out<=in and counter<=0.
  - Result: input stable at the new level for exactly DEBOUNCE_CYC edges produces the output change at that DEBOUNCE_CYC-th edge. Any glitch back to the old level restarts the count.
  - DEBOUNCE_CYC=0: out<=in every cycle (1-cycle latency).
- Remap (combinational on debounced bits, then registered into btn_out; +1 cycle):
  - rot_en=0: identity.
  - rot_en=1: out.U=deb.R, out.R=deb.D, out.D=deb.L, out.L=deb.U. Buttons, starts and coins are unaffected.
  - A rot_en change is visible on btn_out on the next edge.
- Coin edge detect: rising edges of debounced coin1 and coin2 each add 1 to the queue. Both rising in the same cycle adds 2.
- Queue: coin_pending saturates at COIN_QMAX.
  - Each increment beyond COIN_QMAX asserts coin_drop for that cycle; one strobe even if 2 are dropped together.
  - Same-cycle increment and FSM dequeue: net result is pending+inc-1, then saturated.
- Coin FSM:
  - IDLE: if pending>0, dequeue, go to PULSE, coin_out=1 on the next edge.
  - PULSE: count COIN_PULSE_CYC cycles with coin_out=1, then go to HOLDOFF with coin_out=0.
  - HOLDOFF: count COIN_HOLDOFF_CYC cycles, then go to IDLE.
  - IDLE with pending>0 re-enters PULSE immediately, so back-to-back coins have a minimum low gap of COIN_HOLDOFF_CYC+1 cycles.
  - A zero-length PULSE or HOLDOFF count is treated as 1.
- Coin state is independent of rot_en. A coin held down continuously counts once; it must be released and debounced before it counts again.

Decomposition:
- Package arcade_input_pkg holds:
  - raw_in bit-index localparams (IDX_R..IDX_COIN2)
  - coin FSM enum coin_state_t {IDLE, PULSE, HOLDOFF}
  - width helper function for the counter widths
- One sub-module, debounce_bit (params DEBOUNCE_CYC; ports clk_sys, reset, din, dout), instantiated 10 times via generate.
- Remap, queue and FSM stay in the top module.

Test Plan (DEBOUNCE_CYC=4, COIN_PULSE_CYC=8, COIN_HOLDOFF_CYC=6):
- raw_in[4] 0->1 held -> debounced bit flips at edge 4, btn_out[4]=1 at edge 5. A 3-cycle pulse then drop -> btn_out[4] stays 0.
- rot_en=1, raw_in[0]=1 held 10 cycles -> btn_out=8'b0000_1000 (U). Toggle rot_en=0 -> next edge btn_out=8'b0000_0001.
- Single 20-cycle coin1 press -> coin_out high exactly 8 cycles, starting 2 edges after debounce, then low >=7 cycles. coin_pending returns to 0.
- coin1 and coin2 rising in the same cycle -> two 8-cycle pulses separated by 7 low cycles. coin_pending shows 2 then 1 then 0.
- Five separate coin presses during one pulse -> pending saturates at 3, coin_drop strobes once per excess press (twice), exactly 4 pulses total.
- reset asserted mid-PULSE with pending=2 -> coin_out=0 and pending=0 immediately. After release, no further pulses without a new press.
